// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: state sequencer and instruction decoder for the multi-cycle miniRV core.
// Walks FETCH/DECODE/EXEC/MEM/WB with timed ROM/RAM handshakes and decodes the latched inst_q.
module multicycle_ctrl #(
  parameter int ACK_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  output logic        irom_req,
  input  logic        irom_ack,
  input  logic [31:0] irom_inst,
  output logic        dram_req,
  input  logic        dram_ack,
  output logic [31:0] inst_q,
  output logic [2:0]  sext_op,
  output logic [1:0]  npc_op,
  output logic [2:0]  alu_op,
  output logic        alub_sel,
  output logic [1:0]  rf_wsel,
  output logic [2:0]  br_op,
  output logic        pc_we,
  output logic        rf_we,
  output logic        ram_we,
  output logic        instret,
  output logic        illegal,
  output logic        bus_err,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic            TO_EN   = (ACK_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  state_t          state, next_state;
  logic [TO_W-1:0] to_cnt;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic            is_r, f7_zero, f7_alt;
  logic [2:0]      alu_f;
  logic            alu_ok;
  logic            legal, is_mem, is_sw, writes_rd;
  logic            waiting, to_expired, set_illegal, set_bus_err;

  assign opcode  = inst_q[6:0];
  assign rd      = inst_q[11:7];
  assign funct3  = inst_q[14:12];
  assign funct7  = inst_q[31:25];
  assign is_r    = (opcode == OP_R);
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);
  assign state_o = state;

  // For I-type, funct7 is immediate bits except on the shift forms, so only shifts check it there.
  always_comb begin
    alu_f  = 3'b000;
    alu_ok = 1'b0;
    case (funct3)
      3'b000: begin
        alu_f  = (is_r && f7_alt) ? 3'b001 : 3'b000;
        alu_ok = !is_r || f7_zero || f7_alt;
      end
      3'b001: begin alu_f = 3'b101; alu_ok = f7_zero; end
      3'b100: begin alu_f = 3'b100; alu_ok = !is_r || f7_zero; end
      3'b101: begin alu_f = f7_alt ? 3'b111 : 3'b110; alu_ok = f7_zero || f7_alt; end
      3'b110: begin alu_f = 3'b011; alu_ok = !is_r || f7_zero; end
      3'b111: begin alu_f = 3'b010; alu_ok = !is_r || f7_zero; end
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    sext_op   = 3'b111;
    npc_op    = 2'b00;
    alu_op    = 3'b000;
    alub_sel  = 1'b0;
    rf_wsel   = 2'b00;
    br_op     = 3'b111;
    legal     = 1'b0;
    is_mem    = 1'b0;
    is_sw     = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OP_R, OP_I: if (alu_ok) begin
        legal     = 1'b1;
        sext_op   = is_r ? 3'b111 : 3'b000;
        alu_op    = alu_f;
        alub_sel  = !is_r;
        writes_rd = 1'b1;
      end
      OP_LW: if (funct3 == 3'b010) begin
        legal     = 1'b1;
        sext_op   = 3'b000;
        alub_sel  = 1'b1;
        rf_wsel   = 2'b01;
        is_mem    = 1'b1;
        writes_rd = 1'b1;
      end
      OP_SW: if (funct3 == 3'b010) begin
        legal    = 1'b1;
        sext_op  = 3'b001;
        alub_sel = 1'b1;
        is_mem   = 1'b1;
        is_sw    = 1'b1;
      end
      OP_JALR: if (funct3 == 3'b000) begin
        legal     = 1'b1;
        sext_op   = 3'b000;
        npc_op    = 2'b11;
        alub_sel  = 1'b1;
        rf_wsel   = 2'b10;
        writes_rd = 1'b1;
      end
      // Branch funct3 000/001/100/101 compress onto br_op 000..011.
      OP_B: if (funct3[1] == 1'b0) begin
        legal   = 1'b1;
        sext_op = 3'b010;
        npc_op  = 2'b10;
        alu_op  = 3'b001;
        br_op   = {1'b0, funct3[2], funct3[0]};
      end
      OP_LUI: begin
        legal     = 1'b1;
        sext_op   = 3'b011;
        rf_wsel   = 2'b11;
        writes_rd = 1'b1;
      end
      OP_JAL: begin
        legal     = 1'b1;
        sext_op   = 3'b100;
        npc_op    = 2'b01;
        rf_wsel   = 2'b10;
        writes_rd = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  assign waiting    = ((state == FETCH) && !irom_ack) || ((state == MEM) && !dram_ack);
  assign to_expired = TO_EN && (to_cnt == TO_LAST);

  // Next-state and strobes; an ack on the last allowed wait cycle takes priority over the timeout.
  always_comb begin
    next_state  = state;
    irom_req    = 1'b0;
    dram_req    = 1'b0;
    ram_we      = 1'b0;
    pc_we       = 1'b0;
    rf_we       = 1'b0;
    instret     = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state)
      FETCH: begin
        irom_req = !cpu_rst;
        if (irom_ack) begin
          next_state = DECODE;
        end else if (to_expired) begin
          next_state  = TRAP;
          set_bus_err = 1'b1;
        end
      end
      DECODE: begin
        if (legal) begin
          next_state = EXEC;
        end else begin
          next_state  = TRAP;
          set_illegal = 1'b1;
        end
      end
      EXEC: next_state = is_mem ? MEM : WB;
      MEM: begin
        dram_req = 1'b1;
        ram_we   = is_sw;
        if (dram_ack) begin
          next_state = WB;
        end else if (to_expired) begin
          next_state  = TRAP;
          set_bus_err = 1'b1;
        end
      end
      WB: begin
        pc_we      = 1'b1;
        instret    = 1'b1;
        rf_we      = writes_rd && (rd != 5'd0);
        next_state = FETCH;
      end
      TRAP:    next_state = TRAP;
      default: next_state = TRAP;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state   <= FETCH;
      inst_q  <= 32'h0;
      to_cnt  <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == FETCH) && irom_ack) inst_q <= irom_inst;
      to_cnt <= waiting ? to_cnt + TO_W'(1) : '0;
      if (set_illegal) illegal <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: plans each instruction as an expected per-cycle trace built from the
// controller's rules, drives the handshakes from that plan and compares every cycle.
module tb_multicycle_ctrl;

  localparam int TO = 255;
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd7;

  typedef struct {
    bit         legal;
    logic [2:0] sext;
    logic [1:0] npc;
    logic [2:0] alu;
    bit         chk_alu;
    logic       alub;
    bit         chk_alub;
    logic [1:0] wsel;
    bit         chk_wsel;
    logic [2:0] br;
    bit         mem;
    bit         sw;
    bit         wr;
  } dec_t;

  // strb = {irom_req, dram_req, ram_we, pc_we, rf_we, instret, illegal, bus_err}
  typedef struct {
    logic        irom_ack;
    logic [31:0] irom_inst;
    logic        dram_ack;
    logic [2:0]  st;
    logic [7:0]  strb;
    logic [31:0] iq;
    bit          chk_dec;
    dec_t        d;
  } cyc_t;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        irom_ack = 1'b0;
  logic [31:0] irom_inst = 32'h0;
  logic        dram_ack = 1'b0;
  logic        irom_req, dram_req, alub_sel, pc_we, rf_we, ram_we, instret, illegal, bus_err;
  logic [31:0] inst_q;
  logic [2:0]  sext_op, alu_op, br_op, state_o;
  logic [1:0]  npc_op, rf_wsel;
  logic [7:0]  strobes;

  cyc_t        plan[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_inst = 32'h0;
  bit          m_illegal = 0;
  bit          m_bus = 0;

  multicycle_ctrl #(.ACK_TIMEOUT(TO), .TO_W(8)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .irom_req(irom_req), .irom_ack(irom_ack), .irom_inst(irom_inst),
    .dram_req(dram_req), .dram_ack(dram_ack), .inst_q(inst_q),
    .sext_op(sext_op), .npc_op(npc_op), .alu_op(alu_op), .alub_sel(alub_sel),
    .rf_wsel(rf_wsel), .br_op(br_op), .pc_we(pc_we), .rf_we(rf_we), .ram_we(ram_we),
    .instret(instret), .illegal(illegal), .bus_err(bus_err), .state_o(state_o)
  );

  assign strobes = {irom_req, dram_req, ram_we, pc_we, rf_we, instret, illegal, bus_err};

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decoder written straight from the instruction-class table.
  function automatic dec_t ref_decode(input logic [31:0] i);
    dec_t d;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic is_r, ok;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    is_r = (op == 7'b0110011);
    ok = 1'b0;
    d.legal = 0; d.sext = 3'b111; d.npc = 2'b00; d.alu = 3'b000; d.chk_alu = 1;
    d.alub = 0; d.chk_alub = 0; d.wsel = 2'b00; d.chk_wsel = 0; d.br = 3'b111;
    d.mem = 0; d.sw = 0; d.wr = 0;
    case (op)
      7'b0110011, 7'b0010011: begin
        ok = 1'b1;
        casez ({is_r, f3, f7})
          11'b1_000_0000000, 11'b0_000_???????: d.alu = 3'b000;
          11'b1_000_0100000:                    d.alu = 3'b001;
          11'b1_111_0000000, 11'b0_111_???????: d.alu = 3'b010;
          11'b1_110_0000000, 11'b0_110_???????: d.alu = 3'b011;
          11'b1_100_0000000, 11'b0_100_???????: d.alu = 3'b100;
          11'b?_001_0000000:                    d.alu = 3'b101;
          11'b?_101_0000000:                    d.alu = 3'b110;
          11'b?_101_0100000:                    d.alu = 3'b111;
          default:                              ok = 1'b0;
        endcase
        if (ok) begin
          d.legal = 1; d.sext = is_r ? 3'b111 : 3'b000; d.alub = !is_r; d.chk_alub = 1;
          d.wsel = 2'b00; d.chk_wsel = 1; d.wr = 1;
        end else d.alu = 3'b000;
      end
      7'b0000011: if (f3 == 3'b010) begin
        d.legal = 1; d.sext = 3'b000; d.alub = 1; d.chk_alub = 1; d.wsel = 2'b01;
        d.chk_wsel = 1; d.mem = 1; d.wr = 1; d.chk_alu = 0;
      end
      7'b0100011: if (f3 == 3'b010) begin
        d.legal = 1; d.sext = 3'b001; d.alub = 1; d.chk_alub = 1; d.mem = 1; d.sw = 1;
        d.chk_alu = 0;
      end
      7'b1100111: if (f3 == 3'b000) begin
        d.legal = 1; d.sext = 3'b000; d.npc = 2'b11; d.alub = 1; d.chk_alub = 1;
        d.wsel = 2'b10; d.chk_wsel = 1; d.wr = 1; d.chk_alu = 0;
      end
      7'b1100011: begin
        d.chk_alu = 0;
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101) begin
          d.legal = 1; d.sext = 3'b010; d.npc = 2'b10; d.chk_alub = 1;
          d.br = (f3 == 3'b000) ? 3'b000 : (f3 == 3'b001) ? 3'b001 :
                 (f3 == 3'b100) ? 3'b010 : 3'b011;
        end else d.chk_alu = 1;
      end
      7'b0110111: begin
        d.legal = 1; d.sext = 3'b011; d.wsel = 2'b11; d.chk_wsel = 1; d.wr = 1; d.chk_alu = 0;
      end
      7'b1101111: begin
        d.legal = 1; d.sext = 3'b100; d.npc = 2'b01; d.wsel = 2'b10; d.chk_wsel = 1;
        d.wr = 1; d.chk_alu = 0;
      end
      default: d.legal = 0;
    endcase
    return d;
  endfunction

  // Idle cycles carry random stray acks, which the controller must ignore.
  function automatic cyc_t new_rec(input logic [2:0] st);
    cyc_t r;
    r.st        = st;
    r.irom_ack  = ($urandom_range(0, 3) == 0);
    r.dram_ack  = !r.irom_ack && ($urandom_range(0, 3) == 0);
    r.irom_inst = $urandom;
    r.strb      = {6'b0, m_illegal, m_bus};
    r.iq        = m_inst;
    r.chk_dec   = 0;
    r.d         = ref_decode(32'h0);
    return r;
  endfunction

  task automatic push_trap();
    for (int k = 0; k < 3; k++) plan.push_back(new_rec(S_TRAP));
  endtask

  // lf/lm = wait cycles before the ROM/RAM ack; values >= TO never ack.
  task automatic plan_inst(input logic [31:0] inst, input int lf, input int lm, output bit trapped);
    cyc_t r;
    dec_t d;
    d = ref_decode(inst);
    trapped = 0;
    for (int k = 0; k < TO && k <= lf; k++) begin
      r = new_rec(S_FETCH);
      r.strb[7] = 1'b1;
      if (k == lf) begin r.irom_ack = 1; r.irom_inst = inst; r.dram_ack = 0; end
      else r.irom_ack = 0;
      plan.push_back(r);
    end
    if (lf >= TO) begin m_bus = 1; push_trap(); trapped = 1; return; end
    m_inst = inst;
    r = new_rec(S_DECODE); r.chk_dec = 1; r.d = d; plan.push_back(r);
    if (!d.legal) begin m_illegal = 1; push_trap(); trapped = 1; return; end
    r = new_rec(S_EXEC); r.chk_dec = 1; r.d = d; plan.push_back(r);
    if (d.mem) begin
      for (int k = 0; k < TO && k <= lm; k++) begin
        r = new_rec(S_MEM); r.chk_dec = 1; r.d = d;
        r.strb[6] = 1'b1; r.strb[5] = d.sw;
        if (k == lm) begin r.dram_ack = 1; r.irom_ack = 0; end
        else r.dram_ack = 0;
        plan.push_back(r);
      end
      if (lm >= TO) begin m_bus = 1; push_trap(); trapped = 1; return; end
    end
    r = new_rec(S_WB); r.chk_dec = 1; r.d = d;
    r.strb[4] = 1'b1; r.strb[3] = d.wr && (inst[11:7] != 5'd0); r.strb[2] = 1'b1;
    plan.push_back(r);
  endtask

  task automatic applyStimulus(input cyc_t r);
    irom_ack  = r.irom_ack;
    irom_inst = r.irom_inst;
    dram_ack  = r.dram_ack;
  endtask

  task automatic checkOutput(input cyc_t r);
    check("state", state_o, r.st);
    check("strobes", strobes, r.strb);
    check("inst_q", inst_q, r.iq);
    if (r.chk_dec) begin
      check("sext_op", sext_op, r.d.sext);
      check("npc_op", npc_op, r.d.npc);
      check("br_op", br_op, r.d.br);
      if (r.d.chk_alu) check("alu_op", alu_op, r.d.alu);
      if (r.d.chk_alub) check("alub_sel", alub_sel, r.d.alub);
      if (r.d.chk_wsel) check("rf_wsel", rf_wsel, r.d.wsel);
    end
  endtask

  task automatic run_plan(input int max_n);
    cyc_t r;
    int n = 0;
    while (plan.size() > 0 && n < max_n) begin
      r = plan.pop_front();
      applyStimulus(r);
      @(negedge cpu_clk);
      checkOutput(r);
      @(posedge cpu_clk);
      #1;
      n++;
    end
    plan.delete();
  endtask

  task automatic do_reset();
    cpu_rst = 1; irom_ack = 0; dram_ack = 0;
    #1;
    check("rst state", state_o, 32'd0);
    check("rst strobes", strobes, 32'd0);
    check("rst inst_q", inst_q, 32'd0);
    @(posedge cpu_clk);
    #1;
    cpu_rst = 0;
    m_inst = 32'h0; m_illegal = 0; m_bus = 0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 9))
      0: begin
        x[6:0] = 7'b0110011;
        if ($urandom_range(0, 2) == 0) x[31:25] = 7'b0100000;
        else if ($urandom_range(0, 3) != 0) x[31:25] = 7'b0000000;
      end
      1: begin
        x[6:0] = 7'b0010011;
        if ($urandom_range(0, 1) == 0) x[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
      end
      2: begin x[6:0] = 7'b0000011; if ($urandom_range(0, 4) != 0) x[14:12] = 3'b010; end
      3: begin x[6:0] = 7'b0100011; if ($urandom_range(0, 4) != 0) x[14:12] = 3'b010; end
      4: x[6:0] = 7'b1100011;
      5: x[6:0] = 7'b0110111;
      6: x[6:0] = 7'b1101111;
      7: begin x[6:0] = 7'b1100111; if ($urandom_range(0, 4) != 0) x[14:12] = 3'b000; end
      8: ;
      default: begin x[6:0] = 7'b0110011; x[31:25] = 7'h00; x[14:12] = 3'b000; x[11:7] = 5'd0; end
    endcase
    return x;
  endfunction

  initial begin
    dec_t d;
    bit trapped;
    int cnt;

    d = ref_decode(32'h002081B3);
    check("pin add", {d.legal, d.sext, d.npc, d.alu, d.wr}, {1'b1, 3'b111, 2'b00, 3'b000, 1'b1});
    d = ref_decode(32'h40208133);
    check("pin sub", {d.legal, d.alu}, {1'b1, 3'b001});
    d = ref_decode(32'h0080A283);
    check("pin lw", {d.legal, d.sext, d.wsel, d.mem, d.sw}, {1'b1, 3'b000, 2'b01, 1'b1, 1'b0});
    d = ref_decode(32'h0050A223);
    check("pin sw", {d.legal, d.sext, d.mem, d.sw, d.wr}, {1'b1, 3'b001, 1'b1, 1'b1, 1'b0});
    d = ref_decode(32'h00209463);
    check("pin bne", {d.legal, d.sext, d.npc, d.br, d.wr}, {1'b1, 3'b010, 2'b10, 3'b001, 1'b0});
    d = ref_decode(32'h00000000);
    check("pin zero", {d.legal, d.sext, d.br}, {1'b0, 3'b111, 3'b111});

    @(posedge cpu_clk);
    #1;
    do_reset();

    plan_inst(32'h002081B3, 0, 0, trapped);
    check("pin add cycles", plan.size(), 32'd4);
    check("pin add wb", plan[3].st, S_WB);
    run_plan(1000);

    plan_inst(32'h0080A283, 0, 3, trapped);
    cnt = 0;
    foreach (plan[i]) if (plan[i].strb[6]) cnt++;
    check("pin lw dram_req cycles", cnt, 32'd4);
    check("pin lw cycles", plan.size(), 32'd8);
    run_plan(1000);

    plan_inst(32'h0050A223, 1, 2, trapped);
    run_plan(1000);
    plan_inst(32'h00209463, 0, 0, trapped);
    run_plan(1000);
    plan_inst(32'h00500013, 2, 0, trapped);
    run_plan(1000);

    plan_inst(32'h00000000, 0, 0, trapped);
    check("pin trap cycle 3", plan[2].st, S_TRAP);
    run_plan(1000);
    do_reset();

    plan_inst(32'h002081B3, TO - 1, 0, trapped);
    run_plan(1000);
    plan_inst(32'h002081B3, TO + 10, 0, trapped);
    check("pin fetch timeout len", plan.size(), TO + 3);
    run_plan(1000);
    do_reset();
    plan_inst(32'h0080A283, 0, TO + 10, trapped);
    run_plan(1000);
    do_reset();

    plan_inst(32'h0050A223, 0, 20, trapped);
    run_plan(5);
    do_reset();

    for (int n = 0; n < 150; n++) begin
      plan_inst(rand_inst(), $urandom_range(0, 3), $urandom_range(0, 3), trapped);
      run_plan(1000);
      if (trapped) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
